// File: rtl/byte_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : byte_mem_responder_pkg
//  Description : Shared memory map for the byte-serial memory port. It holds
//                the I/O window base, the register offsets inside the window
//                and the bus widths used by the responder and its initiators.
//  Revision    : 1.0  initial release
// ============================================================================
package byte_mem_responder_pkg;

  // Bus widths of the byte-serial port.
  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 8;

  typedef logic [MEM_ADDR_W-1:0] mem_addr_bus_t;
  typedef logic [MEM_DATA_W-1:0] mem_data_bus_t;

  // I/O window: 16 bytes, 16-byte aligned.
  localparam logic [MEM_ADDR_W-1:0] IO_BASE = 32'h0003_0000;

  // Register offsets inside the I/O window. The halt register shares the
  // status offset: reads return status, writes set halt.
  localparam logic [3:0] IO_TX_OFF   = 4'h0;
  localparam logic [3:0] IO_STAT_OFF = 4'h4;

endpackage : byte_mem_responder_pkg
`default_nettype wire

// File: rtl/byte_mem_responder_byte_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : byte_fifo
//  Description : Circular-buffer FIFO. A push is accepted while not full, or
//                while full if a pop happens in the same cycle. A pop request
//                on an empty FIFO is ignored.
//  Ports       : clk, rst_n           clock, async active-low reset
//                push_i, din_i        push request and data
//                pop_i                pop request (head is consumed)
//                dout_o               entry at the read pointer
//                full_o, empty_o      occupancy flags
//  Revision    : 1.0  initial release
// ============================================================================
module byte_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] store [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic pop_ok;
  logic push_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign dout_o  = store[rd_ptr_q];

  // The slot freed by a same-cycle pop lets a push into a full FIFO through.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so pointer wrap is plain binary overflow.
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_ok && !pop_ok)      count_d = count_q + CNT_W'(1);
    else if (pop_ok && !push_ok) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; entries are only visible once the count covers them.
  always_ff @(posedge clk) begin
    if (push_ok) store[wr_ptr_q] <= din_i;
  end

endmodule : byte_fifo
`default_nettype wire

// File: rtl/byte_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : byte_mem_responder
//  Description : Memory-side responder for the byte-serial memory port.
//                Samples one request per rising edge and serves it from an
//                internal byte RAM or from a 16-byte I/O window holding a
//                TX FIFO push port, a status register and a halt register.
//                Read data is registered: an address sampled at edge k+1
//                appears on mem_dout_o after that same edge.
//  Ports       : clk, rst_n          clock, async active-low reset
//                mem_addr_i          byte address (idle initiator parks at 0)
//                mem_we_i            1 = write, 0 = read
//                mem_din_i           write byte
//                mem_dout_o          registered read byte
//                io_tx_data_o        TX FIFO head byte
//                io_tx_valid_o       TX FIFO not empty
//                io_tx_ready_i       sink accepts the head byte
//                io_tx_full_o        TX FIFO full
//                io_tx_overflow_o    sticky: a TX write was dropped
//                sim_halt_o          sticky: halt register written
//  Revision    : 1.0  initial release
// ============================================================================
module byte_mem_responder
  import byte_mem_responder_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 17,
  parameter logic [MEM_ADDR_W-1:0] IO_BASE    = byte_mem_responder_pkg::IO_BASE,
  parameter int                    TX_DEPTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [MEM_ADDR_W-1:0] mem_addr_i,
  input  logic                  mem_we_i,
  input  logic [MEM_DATA_W-1:0] mem_din_i,
  output logic [MEM_DATA_W-1:0] mem_dout_o,
  output logic [MEM_DATA_W-1:0] io_tx_data_o,
  output logic                  io_tx_valid_o,
  input  logic                  io_tx_ready_i,
  output logic                  io_tx_full_o,
  output logic                  io_tx_overflow_o,
  output logic                  sim_halt_o
);

  localparam int RAM_BYTES = 1 << ADDR_WIDTH;

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  logic                  io_sel;
  logic                  ram_sel;
  logic [3:0]            io_off;
  logic [ADDR_WIDTH-1:0] ram_idx;

  assign io_off  = mem_addr_i[3:0];
  assign ram_idx = mem_addr_i[ADDR_WIDTH-1:0];
  assign io_sel  = (mem_addr_i[MEM_ADDR_W-1:4] == IO_BASE[MEM_ADDR_W-1:4]);
  // The I/O window takes priority in case it is ever placed inside RAM space.
  assign ram_sel = !io_sel && ((mem_addr_i >> ADDR_WIDTH) == '0);

  // --------------------------------------------------------------------------
  // Byte RAM (not reset)
  // --------------------------------------------------------------------------
  logic [MEM_DATA_W-1:0] ram_mem [RAM_BYTES];

  // Writes are suppressed while reset is asserted so an aborted transfer
  // leaves no trace in memory.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we_i && ram_sel) ram_mem[ram_idx] <= mem_din_i;
  end

  // --------------------------------------------------------------------------
  // TX FIFO
  // --------------------------------------------------------------------------
  logic tx_push;
  logic tx_pop;
  logic tx_empty;

  assign tx_push       = mem_we_i && io_sel && (io_off == IO_TX_OFF);
  assign tx_pop        = io_tx_valid_o && io_tx_ready_i;
  assign io_tx_valid_o = !tx_empty;

  byte_fifo #(
    .DEPTH (TX_DEPTH),
    .WIDTH (MEM_DATA_W)
  ) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (tx_push),
    .din_i   (mem_din_i),
    .pop_i   (tx_pop),
    .dout_o  (io_tx_data_o),
    .full_o  (io_tx_full_o),
    .empty_o (tx_empty)
  );

  // --------------------------------------------------------------------------
  // Read data and sticky flags
  // --------------------------------------------------------------------------
  logic [MEM_DATA_W-1:0] dout_q, dout_d;
  logic                  overflow_q, overflow_d;
  logic                  halt_q, halt_d;

  always_comb begin
    dout_d     = dout_q;
    overflow_d = overflow_q;
    halt_d     = halt_q;

    // Write cycles leave the read register untouched.
    if (!mem_we_i) begin
      if (ram_sel) begin
        dout_d = ram_mem[ram_idx];
      end else if (io_sel && (io_off == IO_STAT_OFF)) begin
        dout_d = {{(MEM_DATA_W-1){1'b0}}, io_tx_full_o};
      end else begin
        dout_d = '0;
      end
    end

    // A push into a full FIFO is lost unless a pop frees a slot this cycle.
    if (tx_push && io_tx_full_o && !tx_pop) overflow_d = 1'b1;

    if (mem_we_i && io_sel && (io_off == IO_STAT_OFF)) halt_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q     <= '0;
      overflow_q <= 1'b0;
      halt_q     <= 1'b0;
    end else begin
      dout_q     <= dout_d;
      overflow_q <= overflow_d;
      halt_q     <= halt_d;
    end
  end

  assign mem_dout_o       = dout_q;
  assign io_tx_overflow_o = overflow_q;
  assign sim_halt_o       = halt_q;

endmodule : byte_mem_responder
`default_nettype wire

// File: tb/tb_byte_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_byte_mem_responder
//  Description : Self-checking bench for byte_mem_responder. A behavioural
//                model (associative RAM, queue FIFO, flag bits) is advanced
//                once per clock from the driven request; a compare process
//                checks every DUT output against it on each falling edge.
//                Directed scenarios add literal expectations; a randomized
//                phase mixes RAM, I/O and unmapped traffic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_byte_mem_responder;

  localparam logic [31:0] IO_C    = 32'h0003_0000;
  localparam int          DEPTH_C = 16;
  localparam int          RAM_LIM = 1 << 17;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] mem_addr_i = '0;
  logic        mem_we_i = 1'b0;
  logic [7:0]  mem_din_i = '0;
  logic [7:0]  mem_dout_o;
  logic [7:0]  io_tx_data_o;
  logic        io_tx_valid_o;
  logic        io_tx_ready_i = 1'b0;
  logic        io_tx_full_o;
  logic        io_tx_overflow_o;
  logic        sim_halt_o;

  always #5 clk = ~clk;

  byte_mem_responder dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .mem_addr_i       (mem_addr_i),
    .mem_we_i         (mem_we_i),
    .mem_din_i        (mem_din_i),
    .mem_dout_o       (mem_dout_o),
    .io_tx_data_o     (io_tx_data_o),
    .io_tx_valid_o    (io_tx_valid_o),
    .io_tx_ready_i    (io_tx_ready_i),
    .io_tx_full_o     (io_tx_full_o),
    .io_tx_overflow_o (io_tx_overflow_o),
    .sim_halt_o       (sim_halt_o)
  );

  // --------------------------------------------------------------------------
  // Behavioural model
  // --------------------------------------------------------------------------
  logic [7:0] mem_m [int];
  logic [7:0] txq [$];
  bit         ovf_m;
  bit         halt_m;
  logic [7:0] dout_m;
  bit         dout_known;
  bit         chk_en;

  int checks;
  int errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one sampled request.
  task automatic model_step(input logic [31:0] a, input logic we,
                            input logic [7:0] d, input logic rdy);
    int  sz;
    bit  pop;
    bit  io;
    bit  ram;
    int  off;
    sz  = txq.size();
    pop = (sz > 0) && rdy;
    io  = ((a >> 4) == (IO_C >> 4));
    ram = !io && (a < RAM_LIM);
    off = int'(a & 32'hF);
    if (!we) begin
      if (ram) begin
        if (mem_m.exists(int'(a))) begin
          dout_m = mem_m[int'(a)];
          dout_known = 1'b1;
        end else begin
          dout_known = 1'b0;
        end
      end else if (io && off == 4) begin
        dout_m = (sz == DEPTH_C) ? 8'd1 : 8'd0;
        dout_known = 1'b1;
      end else begin
        dout_m = 8'd0;
        dout_known = 1'b1;
      end
    end
    if (pop) void'(txq.pop_front());
    if (we) begin
      if (ram) mem_m[int'(a)] = d;
      else if (io && off == 0) begin
        if (sz < DEPTH_C || pop) txq.push_back(d);
        else ovf_m = 1'b1;
      end else if (io && off == 4) halt_m = 1'b1;
    end
  endtask

  // Compare process: every falling edge while the model is in step.
  always @(negedge clk) begin
    if (chk_en) begin
      if (dout_known) chk("dout", {24'd0, mem_dout_o}, {24'd0, dout_m});
      chk("tx_valid", {31'd0, io_tx_valid_o}, {31'd0, txq.size() > 0});
      chk("tx_full", {31'd0, io_tx_full_o}, {31'd0, txq.size() == DEPTH_C});
      if (txq.size() > 0) chk("tx_data", {24'd0, io_tx_data_o}, {24'd0, txq[0]});
      chk("overflow", {31'd0, io_tx_overflow_o}, {31'd0, ovf_m});
      chk("halt", {31'd0, sim_halt_o}, {31'd0, halt_m});
    end
  end

  // --------------------------------------------------------------------------
  // Drivers
  // --------------------------------------------------------------------------
  task automatic cycle(input logic [31:0] a, input logic we,
                       input logic [7:0] d, input logic rdy);
    mem_addr_i    = a;
    mem_we_i      = we;
    mem_din_i     = d;
    io_tx_ready_i = rdy;
    @(posedge clk);
    model_step(a, we, d, rdy);
    #1;
  endtask

  task automatic do_reset();
    mem_addr_i    = '0;
    mem_we_i      = 1'b0;
    mem_din_i     = '0;
    io_tx_ready_i = 1'b0;
    chk_en        = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_dout", {24'd0, mem_dout_o}, 32'd0);
    chk("rst_valid", {31'd0, io_tx_valid_o}, 32'd0);
    chk("rst_full", {31'd0, io_tx_full_o}, 32'd0);
    chk("rst_overflow", {31'd0, io_tx_overflow_o}, 32'd0);
    chk("rst_halt", {31'd0, sim_halt_o}, 32'd0);
    txq.delete();
    ovf_m      = 1'b0;
    halt_m     = 1'b0;
    dout_m     = 8'd0;
    dout_known = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    #1;
    chk_en = 1'b1;
  endtask

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  initial begin
    logic [7:0] got;
    logic [7:0] pre [4];
    checks = 0;
    errors = 0;
    pre[0] = 8'h11; pre[1] = 8'h22; pre[2] = 8'h33; pre[3] = 8'h44;

    do_reset();

    // Park address has defined contents so idle cycles read a known byte.
    cycle(32'h0, 1'b1, 8'h00, 1'b0);

    // Write then read back a RAM byte.
    cycle(32'h100, 1'b1, 8'hA5, 1'b0);
    cycle(32'h100, 1'b0, 8'h00, 1'b0);
    chk("ram_rd_100", {24'd0, mem_dout_o}, 32'hA5);
    cycle(32'h0, 1'b0, 8'h00, 1'b0);

    // Preload four bytes and stream them back on consecutive edges.
    for (int i = 0; i < 4; i++) cycle(32'h200 + 32'(i), 1'b1, pre[i], 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(32'h200 + 32'(i), 1'b0, 8'h00, 1'b0);
      chk($sformatf("stream_%0d", i), {24'd0, mem_dout_o}, {24'd0, pre[i]});
    end

    // Fill the TX FIFO with the sink stalled, then overflow it.
    for (int i = 0; i < 17; i++) begin
      cycle(IO_C, 1'b1, 8'h10 + 8'(i), 1'b0);
      if (i == 15) begin
        chk("full_after_16", {31'd0, io_tx_full_o}, 32'd1);
        chk("no_ovf_at_16", {31'd0, io_tx_overflow_o}, 32'd0);
      end
    end
    chk("ovf_after_17", {31'd0, io_tx_overflow_o}, 32'd1);
    cycle(IO_C + 32'h4, 1'b0, 8'h00, 1'b0);
    chk("status_full", {24'd0, mem_dout_o}, 32'h01);

    // Reset clears the FIFO and flags; RAM survives.
    do_reset();
    cycle(32'h100, 1'b0, 8'h00, 1'b0);
    chk("ram_kept_1", {24'd0, mem_dout_o}, 32'hA5);

    // Push into a full FIFO while the head pops, then drain.
    for (int i = 0; i < 16; i++) cycle(IO_C, 1'b1, 8'h20 + 8'(i), 1'b0);
    cycle(IO_C, 1'b1, 8'h5A, 1'b1);
    chk("full_after_swap", {31'd0, io_tx_full_o}, 32'd1);
    chk("no_ovf_swap", {31'd0, io_tx_overflow_o}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      got = io_tx_data_o;
      cycle(32'h0, 1'b0, 8'h00, 1'b1);
      if (i == 0)  chk("drain_first", {24'd0, got}, 32'h21);
      if (i == 15) chk("drain_last", {24'd0, got}, 32'h5A);
    end
    chk("drained_empty", {31'd0, io_tx_valid_o}, 32'd0);

    // Halt register, unmapped read, ignored I/O write.
    cycle(IO_C + 32'h4, 1'b1, 8'hFF, 1'b0);
    chk("halt_set", {31'd0, sim_halt_o}, 32'd1);
    cycle(32'h0, 1'b0, 8'h00, 1'b0);
    cycle(32'h0008_0000, 1'b0, 8'h00, 1'b0);
    chk("unmapped_rd", {24'd0, mem_dout_o}, 32'h00);
    cycle(IO_C + 32'h8, 1'b1, 8'h77, 1'b0);
    chk("io8_no_push", {31'd0, io_tx_valid_o}, 32'd0);
    chk("halt_sticky", {31'd0, sim_halt_o}, 32'd1);
    cycle(IO_C + 32'h8, 1'b0, 8'h00, 1'b0);
    chk("io8_rd_zero", {24'd0, mem_dout_o}, 32'h00);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      int          op;
      logic [31:0] a;
      logic        rdy;
      rdy = 1'($urandom_range(0, 1));
      op  = int'($urandom_range(0, 9));
      case (op)
        0, 1, 2, 3: cycle(32'h400 + 32'($urandom_range(0, 63)), 1'b1, 8'($urandom), rdy);
        4, 5:       cycle(32'h400 + 32'($urandom_range(0, 63)), 1'b0, 8'h00, rdy);
        6: begin
          a = IO_C + (($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : 32'h0);
          cycle(a, 1'b1, 8'($urandom), rdy);
        end
        7:          cycle(IO_C + 32'($urandom_range(0, 15)), 1'b0, 8'h00, rdy);
        8: begin
          a = ($urandom_range(0, 1) == 0) ? 32'h0008_0000 + 32'($urandom_range(0, 255))
                                          : 32'hFFFF_0000;
          cycle(a, 1'($urandom_range(0, 1)), 8'($urandom), rdy);
        end
        default:    cycle(32'h0, 1'b0, 8'h00, rdy);
      endcase
    end

    // Reset mid-stream with bytes queued.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(IO_C, 1'b1, 8'h60 + 8'(i), 1'b0);
    chk("five_queued", {31'd0, io_tx_valid_o}, 32'd1);
    do_reset();
    chk("post_rst_empty", {31'd0, io_tx_valid_o}, 32'd0);
    cycle(32'h100, 1'b0, 8'h00, 1'b0);
    chk("ram_kept_2", {24'd0, mem_dout_o}, 32'hA5);
    cycle(32'h0, 1'b0, 8'h00, 1'b0);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_byte_mem_responder
`default_nettype wire

// File: doc/byte_mem_responder.md
Name: byte_mem_responder

Overview:
- Memory-side responder for the byte-serial memory port driven by the MEM stage and the instruction fetch path.
- Accepts one byte request per cycle: address, write enable and write byte.
- Serves requests from an internal byte RAM, or from a small I/O window containing a UART-style TX FIFO, a status register and a halt register.
- Read data returns with the fixed latency the MEM-stage read sequencer expects.

Parameters:
ADDR_WIDTH, 17, RAM index bits; RAM size is 2^ADDR_WIDTH bytes (128 KiB)
IO_BASE, 32'h0003_0000, base address of the I/O window; 16-byte aligned
TX_DEPTH, 16, TX FIFO entries; power of two, at least 2

Ports:
clk  in  1  system clock; all state changes on the rising edge
rst_n  in  1  reset; asynchronous assert, active-low (synchronous deassert handled upstream)
mem_addr_i  in  32  byte address from the initiator; idle initiator parks it at 0
mem_we_i  in  1  1 = write mem_din_i at mem_addr_i; 0 = read
mem_din_i  in  8  write byte
mem_dout_o  out  8  read byte, registered
io_tx_data_o  out  8  TX FIFO head byte
io_tx_valid_o  out  1  TX FIFO not empty
io_tx_ready_i  in  1  sink accepts the head byte when valid and ready are both 1
io_tx_full_o  out  1  TX FIFO holds TX_DEPTH entries
io_tx_overflow_o  out  1  sticky: a TX write was dropped
sim_halt_o  out  1  sticky: the halt register was written

Behaviour:
- Reset (rst_n=0, asynchronous):
  - mem_dout_o, io_tx_overflow_o and sim_halt_o clear to 0.
  - FIFO pointers and count clear to 0, so io_tx_valid_o=0 and io_tx_full_o=0.
  - RAM contents are not reset and keep their values.
  - Reset asserted mid-transfer aborts it with no partial effects after release.
- Decode, combinational from mem_addr_i:
  - io_sel = (mem_addr_i[31:4] == IO_BASE[31:4]).
  - ram_sel = !io_sel && (mem_addr_i >> ADDR_WIDTH) == 0.
  - Anything else is unmapped.
- Request sampling: the responder samples the request on every rising edge; there is no request-valid signal.
- Read timing:
  - If the initiator drives the address after edge k, the responder samples it at edge k+1.
  - mem_dout_o is updated at edge k+1 and holds until the next edge.
  - The initiator captures the byte at edge k+2, so back-to-back addresses stream one byte per cycle.
- Read sources:
  - RAM read returns the stored byte.
  - IO offset 0x4 returns {7'b0, io_tx_full_o}.
  - Any other IO offset returns 0x00; unmapped reads return 0x00.
- Write side effects:
  - mem_dout_o keeps its previous value on a write cycle.
- Write targets:
  - RAM write stores the byte at edge k+1.
  - A read of the same address sampled at edge k+2 or later returns the new byte.
  - IO offset 0x0 pushes mem_din_i into the TX FIFO.
  - IO offset 0x4 sets sim_halt_o.
  - Other IO offsets and unmapped writes are ignored.
- TX FIFO:
  - Circular buffer with read/write pointers modulo TX_DEPTH and a count of clog2(TX_DEPTH)+1 bits.
  - Pop occurs when io_tx_valid_o and io_tx_ready_i are both 1.
  - Push is accepted when count<TX_DEPTH, or when full and a pop happens in the same cycle; the count is then unchanged.
  - A push while full with no pop is dropped, the FIFO is unchanged and io_tx_overflow_o is set.
  - Simultaneous push and pop when empty: pop is not possible, so the push is accepted and count becomes 1.
  - io_tx_data_o is the entry at the read pointer.
  - Pointer wrap from TX_DEPTH-1 to 0 is seamless.
- Sticky flags: sim_halt_o and io_tx_overflow_o clear only on reset.

Decomposition:
- Shared memory-map package holds:
  - IO_BASE;
  - offsets IO_TX_OFF=4'h0 and IO_STAT_OFF=4'h4 (halt shares 0x4 on write);
  - MemAddrBus/MemDataBus widths.
- One sub-module: byte_fifo, parameterised by DEPTH and WIDTH, with push/pop/full/empty ports and accept-on-pop-when-full behaviour.
- Decode, RAM and registers stay in byte_mem_responder.

Test Plan:
- Write 0xA5 to 0x100, then read 0x100 → mem_dout_o=0xA5 at the edge after the read address is sampled; the initiator captures 0xA5 two edges after driving it.
- Preload 0x200..0x203 = 11,22,33,44 and drive four consecutive read addresses → mem_dout_o returns 11,22,33,44 on four consecutive edges.
- With io_tx_ready_i=0, write 17 bytes to 0x30000:
  - io_tx_full_o=1 after the 16th write;
  - the 17th write is dropped and io_tx_overflow_o=1;
  - a read of 0x30004 returns 0x01.
- With the FIFO full, push 0x5A while io_tx_ready_i=1 → head pops, 0x5A is accepted, count stays 16, no overflow; then drain all 16 → bytes arrive in order with 0x5A last, pointers wrap.
- Write to 0x30004 → sim_halt_o=1 and stays 1; read of unmapped 0x80000 returns 0x00; write to 0x30008 has no effect.
- Assert rst_n low mid-stream with 5 bytes queued → outputs clear immediately; after release FIFO empty, RAM byte at 0x100 still 0xA5.
